// File: rtl/psram_pkg.sv
// PSRAM line cache: shared geometry, address fields and FSM encoding.
// Imported by the cache top and its line RAM.
package psram_pkg;

  localparam int ADR_MSB  = 23;
  localparam int LINE_OFF = 6;
  localparam int QW_BYTES = 16;
  localparam int LINE_QWS = 4;
  localparam int QW_W     = QW_BYTES * 8;
  localparam int QSEL_W   = 2;
  localparam int WSEL_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT
  } state_e;

  // Place a CPU word's byte enables at its lane in a quadword.
  function automatic logic [QW_BYTES-1:0] word_ben(
    input logic [WSEL_W-1:0] w,
    input logic [3:0]        be
  );
    word_ben = 16'(be) << {w, 2'b00};
  endfunction

endpackage

// File: rtl/cache_dpram.sv
// Line RAM: quadword-wide true dual-port, byte writes on the CPU side,
// full-width writes on the controller side, registered read data.
module cache_dpram
  import psram_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                a_en_i,
  input  logic [QW_BYTES-1:0] a_be_i,
  input  logic [AW-1:0]       a_addr_i,
  input  logic [QW_W-1:0]     a_wdata_i,
  output logic [QW_W-1:0]     a_rdata_o,
  input  logic                b_en_i,
  input  logic                b_we_i,
  input  logic [AW-1:0]       b_addr_i,
  input  logic [QW_W-1:0]     b_wdata_i,
  output logic [QW_W-1:0]     b_rdata_o
);

  logic [QW_W-1:0] mem_q [2**AW];
  logic [QW_W-1:0] a_rdata_q;
  logic [QW_W-1:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < QW_BYTES; i++) begin
      if (a_en_i && a_be_i[i])
        mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
    end
    if (b_en_i && b_we_i)
      mem_q[b_addr_i] <= b_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i)
        a_rdata_q <= mem_q[a_addr_i];
      if (b_en_i)
        b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/psram_cache.sv
// Direct-mapped write-back cache of 64-byte lines in front of a PSRAM
// controller; the controller moves line data through a side RAM port.
module psram_cache
  import psram_pkg::*;
#(
  parameter int INDEX_W = 4
) (
  input  logic            mem_clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [23:2]     cpu_adr,
  input  logic [3:0]      cpu_ben,
  input  logic [31:0]     cpu_wdata,
  output logic [31:0]     cpu_rdata,
  output logic            cpu_ack,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [23:6]     raddr,
  output logic [23:6]     waddr,
  input  logic            rd_busy,
  input  logic            wr_busy,
  input  logic            cache_en,
  input  logic            cache_we,
  input  logic [1:0]      cache_addr,
  input  logic [QW_W-1:0] cache_wdata,
  output logic [QW_W-1:0] cache_rdata
);

  localparam int TAG_W = ADR_MSB + 1 - LINE_OFF - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;
  localparam int RAM_AW = INDEX_W + QSEL_W;
  localparam int TAG_LO = LINE_OFF + INDEX_W;

  state_e state_q, state_d;

  logic [23:2]        adr_q;
  logic               we_q;
  logic [3:0]         ben_q;
  logic [31:0]        wdata_q;
  logic [TAG_W-1:0]   tags_q [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [23:6]        raddr_q;
  logic [23:6]        waddr_q;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [QSEL_W-1:0]  req_qw;
  logic [WSEL_W-1:0]  req_ws;
  logic [INDEX_W-1:0] cpu_idx;
  logic [QSEL_W-1:0]  cpu_qw;
  logic               hit;

  logic               latch;
  logic               miss;
  logic               ack;
  logic               fill_done;
  logic               ram_en;
  logic [QW_BYTES-1:0] ram_be;
  logic [RAM_AW-1:0]  ram_addr;
  logic [QW_W-1:0]    ram_rdata;

  assign req_idx = adr_q[LINE_OFF+INDEX_W-1:LINE_OFF];
  assign req_tag = adr_q[ADR_MSB:TAG_LO];
  assign req_qw  = adr_q[5:4];
  assign req_ws  = adr_q[3:2];
  assign cpu_idx = cpu_adr[LINE_OFF+INDEX_W-1:LINE_OFF];
  assign cpu_qw  = cpu_adr[5:4];

  assign hit = valid_q[req_idx] &&
               (tags_q[req_idx] == req_tag);

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    miss      = 1'b0;
    ack       = 1'b0;
    fill_done = 1'b0;
    ram_en    = 1'b0;
    ram_be    = '0;
    ram_addr  = {req_idx, req_qw};
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          latch    = 1'b1;
          ram_en   = 1'b1;
          ram_addr = {cpu_idx, cpu_qw};
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          ack     = 1'b1;
          state_d = IDLE;
          if (we_q) begin
            ram_en = 1'b1;
            ram_be = word_ben(req_ws, ben_q);
          end
        end else begin
          miss = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx])
            state_d = WB_REQ;
          else
            state_d = FILL_REQ;
        end
      end
      WB_REQ: begin
        if (wr_busy)
          state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (!wr_busy)
          state_d = FILL_REQ;
      end
      FILL_REQ: begin
        if (rd_busy)
          state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        // Replay the lookup; the line is now resident.
        if (!rd_busy) begin
          fill_done = 1'b1;
          ram_en    = 1'b1;
          state_d   = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      ben_q   <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        adr_q   <= cpu_adr;
        we_q    <= cpu_we;
        ben_q   <= cpu_ben;
        wdata_q <= cpu_wdata;
      end
      if (miss) begin
        raddr_q <= {req_tag, req_idx};
        waddr_q <= {tags_q[req_idx], req_idx};
      end
      if (ack && we_q)
        dirty_q[req_idx] <= 1'b1;
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (fill_done && !reset)
      tags_q[req_idx] <= req_tag;
  end

  cache_dpram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk_i     (mem_clk),
    .rst_i     (reset),
    .a_en_i    (ram_en),
    .a_be_i    (ram_be),
    .a_addr_i  (ram_addr),
    .a_wdata_i ({4{wdata_q}}),
    .a_rdata_o (ram_rdata),
    .b_en_i    (cache_en),
    .b_we_i    (cache_we),
    .b_addr_i  ({req_idx, cache_addr}),
    .b_wdata_i (cache_wdata),
    .b_rdata_o (cache_rdata)
  );

  assign cpu_ack   = ack;
  assign cpu_rdata = ack ? ram_rdata[{req_ws, 5'b0} +: 32]
                         : '0;
  assign mem_rd    = (state_q == FILL_REQ);
  assign mem_wr    = (state_q == WB_REQ);
  assign raddr     = raddr_q;
  assign waddr     = waddr_q;

endmodule
